// File: rtl/nios_systyem_edge_pio_pkg.sv
// Shared register map and edge-type encodings for the edge-capturing PIO.
package nios_systyem_edge_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
    localparam logic [1:0] ADDR_INFO     = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // INFO read word: width in [5:0], edge type in [9:8].
    function automatic logic [31:0] info_word(input int dw, input int et);
        logic [31:0] w;
        w       = '0;
        w[5:0]  = dw[5:0];
        w[9:8]  = et[1:0];
        return w;
    endfunction

endpackage

// File: rtl/nios_systyem_debounce.sv
// Input conditioner: 2-flop synchronizer then a tick-sampled two-agreement filter.
// Latency: 2 cycles sync, plus up to two tick periods (none when DEBOUNCE_CYCLES=0).
// Backpressure: none; free-running every clock.
module nios_systyem_debounce
    import nios_systyem_edge_pio_pkg::*;
#(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] db_dat
);

    logic [DATA_WIDTH-1:0] sync1_q, sync1_d;
    logic [DATA_WIDTH-1:0] sync2_q, sync2_d;
    logic [DATA_WIDTH-1:0] db_q, db_d;

    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_comb begin
                db_d = sync2_q;
            end
        end else begin : g_filter
            localparam int               CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

            logic [CNT_W-1:0]      cnt_q, cnt_d;
            logic [DATA_WIDTH-1:0] samp_q, samp_d;
            logic [DATA_WIDTH-1:0] agree;
            logic                  tick;

            // A bit only moves when the same level was seen on two consecutive ticks.
            always_comb begin
                tick   = (cnt_q == CNT_LAST);
                cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
                agree  = ~(sync2_q ^ samp_q);
                samp_d = tick ? sync2_q : samp_q;
                db_d   = tick ? ((agree & sync2_q) | (~agree & db_q)) : db_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q  <= '0;
                    samp_q <= '0;
                end else begin
                    cnt_q  <= cnt_d;
                    samp_q <= samp_d;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            db_q <= '0;
        end else begin
            db_q <= db_d;
        end
    end

    assign db_dat = db_q;

endmodule

// File: rtl/nios_systyem_edge_pio.sv
// Avalon-MM PIO: debounced inputs, edge capture with W1C, maskable level irq, output register.
// Latency: readdata 1 cycle after address; irq 1 cycle after capture&mask; edge capture 1 cycle after db moves.
// Backpressure: none; slave accepts every access with zero wait states.
module nios_systyem_edge_pio
    import nios_systyem_edge_pio_pkg::*;
#(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    EDGE_TYPE       = 0,
    parameter int                    DEBOUNCE_CYCLES = 50000,
    parameter logic [DATA_WIDTH-1:0] RESET_OUT       = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  irq
);

    localparam logic [31:0] INFO_WORD = info_word(DATA_WIDTH, EDGE_TYPE);

    logic [DATA_WIDTH-1:0] db;
    logic [DATA_WIDTH-1:0] db_dly_q, db_dly_d;
    logic [DATA_WIDTH-1:0] out_port_q, out_port_d;
    logic [DATA_WIDTH-1:0] irq_mask_q, irq_mask_d;
    logic [DATA_WIDTH-1:0] edge_cap_q, edge_cap_d;
    logic                  irq_q, irq_d;
    logic [31:0]           readdata_q, readdata_d;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] wr_dat;
    logic [DATA_WIDTH-1:0] w1c;
    logic [DATA_WIDTH-1:0] edge_hit;
    logic                  unused_wdata;

    nios_systyem_debounce #(
        .DATA_WIDTH      (DATA_WIDTH),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .db_dat  (db)
    );

    always_comb begin
        wr_en        = chipselect & ~write_n;
        wr_dat       = writedata[DATA_WIDTH-1:0];
        unused_wdata = ^writedata;
        w1c          = (wr_en && (address == ADDR_EDGE_CAP)) ? wr_dat : '0;
    end

    always_comb begin
        case (EDGE_TYPE)
            EDGE_RISING:  edge_hit = db & ~db_dly_q;
            EDGE_FALLING: edge_hit = ~db & db_dly_q;
            default:      edge_hit = db ^ db_dly_q;
        endcase
    end

    // A new edge beats a coincident clear on the same bit.
    always_comb begin
        db_dly_d   = db;
        edge_cap_d = (edge_cap_q & ~w1c) | edge_hit;
        irq_d      = |(edge_cap_q & irq_mask_q);
        out_port_d = (wr_en && (address == ADDR_DATA))     ? wr_dat : out_port_q;
        irq_mask_d = (wr_en && (address == ADDR_IRQ_MASK)) ? wr_dat : irq_mask_q;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d[DATA_WIDTH-1:0] = db;
            ADDR_IRQ_MASK: readdata_d[DATA_WIDTH-1:0] = irq_mask_q;
            ADDR_EDGE_CAP: readdata_d[DATA_WIDTH-1:0] = edge_cap_q;
            ADDR_INFO:     readdata_d                 = INFO_WORD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            db_dly_q   <= '0;
            out_port_q <= RESET_OUT;
            irq_mask_q <= '0;
            edge_cap_q <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            db_dly_q   <= db_dly_d;
            out_port_q <= out_port_d;
            irq_mask_q <= irq_mask_d;
            edge_cap_q <= edge_cap_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_port_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_nios_systyem_edge_pio.sv
// Three PIO instances on shared stimulus, checked against a behavioural model via a read scoreboard.
module tb_nios_systyem_edge_pio;
    import nios_systyem_edge_pio_pkg::*;

    localparam int DW = 8;
    localparam int NI = 3;
    // instance 0: rising, debounce 4; instance 1: any edge, debounce 4; instance 2: falling, no debounce
    localparam logic [NI-1:0][1:0]    ET_P = {2'd1, 2'd2, 2'd0};
    localparam logic [NI-1:0][31:0]   DB_P = {32'd0, 32'd4, 32'd4};
    localparam logic [NI-1:0][DW-1:0] RO_P = {8'h00, 8'hC3, 8'h00};

    typedef struct packed {
        logic [NI-1:0][31:0] exp;
        logic [NI-1:0]       dchk;
        logic [NI-1:0][31:0] dexp;
        int                  id;
    } sb_t;

    logic                  clk;
    logic                  reset;
    logic [1:0]            address;
    logic                  chipselect;
    logic                  write_n;
    logic [31:0]           writedata;
    logic [DW-1:0]         in_port;
    logic [NI-1:0][31:0]   rdata;
    logic [NI-1:0][DW-1:0] out_p;
    logic [NI-1:0]         irq_o;

    int n_tests = 0;
    int n_fail  = 0;

    // read request side-band driven with the address
    logic                rd_req;
    int                  dir_id;
    logic [NI-1:0]       dir_mask;
    logic [NI-1:0][31:0] dir_val;

    sb_t sbq[$];
    logic                  rd_vld   = 1'b0;
    logic                  mon_en   = 1'b0;
    logic                  m_in_rst = 1'b0;
    logic [DW-1:0]         in_hist[$];
    int                    m_cyc;
    logic [NI-1:0][DW-1:0] m_samp, m_db, m_dbd, m_cap, m_mask, m_out;
    logic [NI-1:0]         m_irq;

    nios_systyem_edge_pio #(.DATA_WIDTH(DW), .EDGE_TYPE(int'(ET_P[0])), .DEBOUNCE_CYCLES(int'(DB_P[0])), .RESET_OUT(RO_P[0])) u_dut0 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[0]), .in_port(in_port), .out_port(out_p[0]), .irq(irq_o[0]));
    nios_systyem_edge_pio #(.DATA_WIDTH(DW), .EDGE_TYPE(int'(ET_P[1])), .DEBOUNCE_CYCLES(int'(DB_P[1])), .RESET_OUT(RO_P[1])) u_dut1 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[1]), .in_port(in_port), .out_port(out_p[1]), .irq(irq_o[1]));
    nios_systyem_edge_pio #(.DATA_WIDTH(DW), .EDGE_TYPE(int'(ET_P[2])), .DEBOUNCE_CYCLES(int'(DB_P[2])), .RESET_OUT(RO_P[2])) u_dut2 (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect), .write_n(write_n),
        .writedata(writedata), .readdata(rdata[2]), .in_port(in_port), .out_port(out_p[2]), .irq(irq_o[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [u%0d] got=0x%0h want=0x%0h t=%0t", nm, inst, act, exp, $time);
        end
    endtask

    // Reference model: evaluated at each clock edge from the pre-edge view of the world.
    always @(posedge clk) begin : model
        logic [DW-1:0] sync_v, hit, w1c;
        logic          wr;
        logic [31:0]   rexp;
        sb_t           ent;
        if (reset) begin
            in_hist.delete();
            in_hist.push_back('0);
            in_hist.push_back('0);
            m_cyc = 0;
            m_samp = '0; m_db = '0; m_dbd = '0; m_cap = '0; m_mask = '0; m_irq = '0;
            m_out = RO_P;
            rd_vld = 1'b0;
            m_in_rst = 1'b1;
            mon_en = 1'b1;
        end else begin
            m_in_rst = 1'b0;
            sync_v = in_hist[0];   // external level as seen two edges ago
            wr  = chipselect && !write_n;
            w1c = (wr && address == ADDR_EDGE_CAP) ? writedata[DW-1:0] : '0;
            ent.id = dir_id; ent.dchk = dir_mask; ent.dexp = dir_val; ent.exp = '0;
            for (int i = 0; i < NI; i++) begin
                case (address)
                    ADDR_DATA:     rexp = 32'(m_db[i]);
                    ADDR_IRQ_MASK: rexp = 32'(m_mask[i]);
                    ADDR_EDGE_CAP: rexp = 32'(m_cap[i]);
                    default:       rexp = 32'(DW) | (32'(ET_P[i]) << 8);
                endcase
                ent.exp[i] = rexp;
                case (ET_P[i])
                    2'd0:    hit = m_db[i] & ~m_dbd[i];
                    2'd1:    hit = ~m_db[i] & m_dbd[i];
                    default: hit = m_db[i] ^ m_dbd[i];
                endcase
                m_irq[i] = |(m_cap[i] & m_mask[i]);
                m_cap[i] = (m_cap[i] & ~w1c) | hit;
                if (wr && address == ADDR_IRQ_MASK) m_mask[i] = writedata[DW-1:0];
                if (wr && address == ADDR_DATA)     m_out[i]  = writedata[DW-1:0];
                m_dbd[i] = m_db[i];
                if (DB_P[i] == 0) begin
                    m_db[i] = sync_v;
                end else if ((m_cyc % int'(DB_P[i])) == int'(DB_P[i]) - 1) begin
                    for (int b = 0; b < DW; b++)
                        if (sync_v[b] == m_samp[i][b]) m_db[i][b] = sync_v[b];
                    m_samp[i] = sync_v;
                end
            end
            m_cyc++;
            void'(in_hist.pop_front());
            in_hist.push_back(in_port);
            if (rd_req) sbq.push_back(ent);
            rd_vld = rd_req;
        end
    end

    always @(negedge clk) begin : monitor
        sb_t ent;
        if (mon_en) begin
            for (int i = 0; i < NI; i++) begin
                chk("irq", i, 32'(irq_o[i]), 32'(m_irq[i]));
                chk("out_port", i, 32'(out_p[i]), 32'(m_out[i]));
                if (m_in_rst) chk("readdata_in_reset", i, rdata[i], 32'h0);
            end
            if (rd_vld) begin
                if (sbq.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL scoreboard_empty got=0 entries want>=1 t=%0t", $time);
                end else begin
                    ent = sbq.pop_front();
                    for (int i = 0; i < NI; i++) begin
                        chk("readdata_model", i, rdata[i], ent.exp[i]);
                        if (ent.dchk[i]) chk($sformatf("read_id%0d", ent.id), i, rdata[i], ent.dexp[i]);
                    end
                end
            end
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic cs = 1'b1);
        address = a; chipselect = cs; write_n = 1'b0; writedata = d;
        step();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, input int id, input logic [NI-1:0] m,
                      input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
        address = a; rd_req = 1'b1; dir_id = id; dir_mask = m; dir_val = {d2, d1, d0};
        step();
        rd_req = 1'b0; dir_mask = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        for (int i = 0; i < NI; i++) begin
            chk("reset_out_port", i, 32'(out_p[i]), 32'(RO_P[i]));
            chk("reset_irq", i, 32'(irq_o[i]), 32'h0);
            chk("reset_readdata", i, rdata[i], 32'h0);
        end
        reset = 1'b0;
    endtask

    initial begin : watchdog
        #500000;
        n_fail++;
        $display("FAIL watchdog got=timeout want=completion t=%0t", $time);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : stim
        reset = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
        in_port = '0; rd_req = 1'b0; dir_id = 0; dir_mask = '0; dir_val = '0;
        step(1);
        do_reset();

        // identification and idle data
        rd(ADDR_INFO, 1, 3'b111, 32'h0000_0008, 32'h0000_0208, 32'h0000_0108);
        rd(ADDR_DATA, 2, 3'b111, 32'h0, 32'h0, 32'h0);

        // held rising input on bit0
        in_port = 8'h01;
        step(11);
        rd(ADDR_DATA, 3, 3'b111, 32'h1, 32'h1, 32'h1);
        rd(ADDR_EDGE_CAP, 4, 3'b111, 32'h1, 32'h1, 32'h0);

        // return low, clear everything, then a 3-cycle glitch
        in_port = 8'h00;
        step(12);
        wr(ADDR_EDGE_CAP, 32'hFF);
        wr(ADDR_IRQ_MASK, 32'h01);
        in_port = 8'h01;
        step(3);
        in_port = 8'h00;
        step(12);
        rd(ADDR_DATA, 5, 3'b011, 32'h0, 32'h0, 32'h0);
        rd(ADDR_EDGE_CAP, 6, 3'b011, 32'h0, 32'h0, 32'h0);
        chk("glitch_irq", 0, 32'(irq_o[0]), 32'h0);
        chk("glitch_irq", 1, 32'(irq_o[1]), 32'h0);

        // masked edge raises irq, W1C drops it a cycle later
        in_port = 8'h01;
        step(13);
        chk("edge_irq", 0, 32'(irq_o[0]), 32'h1);
        chk("edge_irq", 1, 32'(irq_o[1]), 32'h1);
        wr(ADDR_EDGE_CAP, 32'h01);
        step(1);
        chk("w1c_irq", 0, 32'(irq_o[0]), 32'h0);
        chk("w1c_irq", 1, 32'(irq_o[1]), 32'h0);

        // falling edge on the undebounced instance lands on the same edge as a W1C
        in_port = 8'h00;
        step(3);
        wr(ADDR_EDGE_CAP, 32'h01);
        rd(ADDR_EDGE_CAP, 7, 3'b100, 32'h0, 32'h0, 32'h1);

        // output register, ignored INFO write, reset value
        wr(ADDR_DATA, 32'hA5);
        for (int i = 0; i < NI; i++) chk("out_write", i, 32'(out_p[i]), 32'hA5);
        wr(ADDR_INFO, 32'hFFFF_FFFF);
        rd(ADDR_INFO, 8, 3'b111, 32'h0000_0008, 32'h0000_0208, 32'h0000_0108);
        rd(ADDR_IRQ_MASK, 9, 3'b111, 32'h1, 32'h1, 32'h1);
        for (int i = 0; i < NI; i++) chk("out_after_info_write", i, 32'(out_p[i]), 32'hA5);
        step(12);
        do_reset();
        rd(ADDR_EDGE_CAP, 10, 3'b111, 32'h0, 32'h0, 32'h0);

        // any-edge instance: bit3 rise and fall
        in_port = 8'h08;
        step(13);
        rd(ADDR_EDGE_CAP, 11, 3'b010, 32'h0, 32'h08, 32'h0);
        wr(ADDR_EDGE_CAP, 32'hF7);
        rd(ADDR_EDGE_CAP, 12, 3'b010, 32'h0, 32'h08, 32'h0);
        wr(ADDR_EDGE_CAP, 32'h08);
        rd(ADDR_EDGE_CAP, 13, 3'b010, 32'h0, 32'h00, 32'h0);
        in_port = 8'h00;
        step(13);
        rd(ADDR_EDGE_CAP, 14, 3'b010, 32'h0, 32'h08, 32'h0);
        wr(ADDR_EDGE_CAP, 32'h08);
        rd(ADDR_EDGE_CAP, 15, 3'b010, 32'h0, 32'h00, 32'h0);

        // randomized traffic against the model
        for (int it = 0; it < 1500; it++) begin
            case ($urandom_range(0, 11))
                0, 1:    in_port = 8'($urandom);
                2:       in_port = in_port ^ (8'h01 << $urandom_range(0, 7));
                3:       wr(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 3) != 0));
                4:       wr(ADDR_EDGE_CAP, $urandom);
                5, 6, 7: rd(2'($urandom_range(0, 3)), 0, '0, 32'h0, 32'h0, 32'h0);
                8, 9:    step($urandom_range(1, 12));
                10:      wr(ADDR_IRQ_MASK, $urandom);
                default: if ($urandom_range(0, 15) == 0) do_reset(); else step(1);
            endcase
        end

        step(3);
        chk("scoreboard_drained", 0, 32'(sbq.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nios_systyem_edge_pio.md
NIOS_SYSTYEM_EDGE_PIO -- requirements
Module: nios_systyem_edge_pio

Interface
REQ-001 Parameter DATA_WIDTH, default 8, width of in_port, out_port and all per-bit registers (1..32).
REQ-002 Parameter EDGE_TYPE, default 0, edge captured: 0 rising, 1 falling, 2 any.
REQ-003 Parameter DEBOUNCE_CYCLES, default 50000, sample-tick period in clk cycles; 0 bypasses debounce.
REQ-004 Parameter RESET_OUT, default 0, out_port reset value (DATA_WIDTH bits).
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 address  input  2  Avalon-MM word address.
REQ-008 chipselect  input  1  Avalon slave select.
REQ-009 write_n  input  1  active-low write strobe.
REQ-010 writedata  input  32  write data.
REQ-011 readdata  output  32  registered read data.
REQ-012 in_port  input  DATA_WIDTH  asynchronous external inputs (switches/keys).
REQ-013 out_port  output  DATA_WIDTH  output data register.
REQ-014 irq  output  1  level interrupt, active-high.

Function
REQ-015 Register map: 0 DATA (R debounced input, W out_port), 1 IRQ_MASK (RW), 2 EDGE_CAPTURE (R; W1C), 3 INFO (R: [5:0]=DATA_WIDTH, [9:8]=EDGE_TYPE; writes ignored).
REQ-016 Write occurs when chipselect=1 and write_n=0; only writedata[DATA_WIDTH-1:0] used; upper readdata bits zero.
REQ-017 readdata updates every cycle from selected register (address registered with data), so readdata is valid 1 cycle after address is presented.
REQ-018 in_port passes a 2-flop synchronizer (sync) before any other use.
REQ-019 Prescaler counts 0..DEBOUNCE_CYCLES-1, asserting tick for one cycle at terminal count then wrapping to 0.
REQ-020 On tick: samp <= sync; per bit, db <= sync when sync==samp, else db holds (value must match at two consecutive ticks).
REQ-021 DEBOUNCE_CYCLES=0: db <= sync each cycle; prescaler omitted.
REQ-022 db_d holds db delayed one cycle; edge detected per bit from db vs db_d per EDGE_TYPE.
REQ-023 Detected edge sets EDGE_CAPTURE bit; bit stays set until a write to address 2 with 1 in that bit position.
REQ-024 Simultaneous W1C and new edge on same bit: bit remains set (set wins).
REQ-025 irq = OR over (EDGE_CAPTURE & IRQ_MASK), registered, asserted 1 cycle after the capture bit and mask are both set.
REQ-026 Writing IRQ_MASK never alters EDGE_CAPTURE; masking a pending bit drops irq next cycle.

Reset
REQ-027 On reset: readdata=0, out_port=RESET_OUT, IRQ_MASK=0, EDGE_CAPTURE=0, irq=0, prescaler=0.
REQ-028 On reset sync, samp, db, db_d load 0, and no edge is captured in the first cycle after reset release.
REQ-029 Reset asserted mid-debounce discards the pending sample and restarts the prescaler from 0.

Structure
REQ-030 Shared package holds the register address constants (ADDR_DATA/IRQ_MASK/EDGE_CAP/INFO) and EDGE_TYPE encodings.
REQ-031 Debounce (synchronizer, prescaler, samp, db) is one sub-module, nios_systyem_debounce, parametrised by DATA_WIDTH and DEBOUNCE_CYCLES.

Verification
REQ-032 Reset, then read addr 3 -> readdata=0x00000008 (DATA_WIDTH=8, EDGE_TYPE=0); read addr 0 -> 0.
REQ-033 DEBOUNCE_CYCLES=4, in_port 0x00->0x01 held -> DATA reads 0x01 by 2 ticks plus 3 cycles after the change, with EDGE_CAPTURE=0x01.
REQ-034 in_port bit0 glitches high for 3 cycles (< 1 tick, DEBOUNCE_CYCLES=4) -> db, EDGE_CAPTURE and irq stay 0.
REQ-035 IRQ_MASK=0x01, edge on bit0 -> irq=1; write 0x01 to addr 2 -> irq=0 next cycle; W1C coincident with new edge -> bit stays 1.
REQ-036 Write 0xA5 to addr 0 -> out_port=0xA5 next cycle; write to addr 3 -> no register change; reset -> out_port=RESET_OUT.
REQ-037 EDGE_TYPE=2, bit3 rises then falls -> EDGE_CAPTURE bit3 set after each edge, cleared only by W1C.
